// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: rotates one low row, reduces each full
// scan to a single-key candidate, debounces it across scans, reports key events.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DW = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic {IDLE, PRESSED} state_t;

  state_t          state;
  logic [3:0]      col_meta, col_sync;
  logic [PW-1:0]   presc;
  logic [1:0]      row_idx;
  logic [1:0]      acc_cnt;
  logic [3:0]      acc_code;
  logic            cand_key;
  logic [3:0]      cand_code;
  logic [DW-1:0]   db_cnt;

  logic            slot_tick, scan_done;
  logic [3:0]      hits;
  logic            row_any, row_many;
  logic [1:0]      first_col;
  logic [1:0]      sum_cnt;
  logic [3:0]      next_code;
  logic            res_key, same;
  logic [DW-1:0]   cnt_next;
  logic            cand_key_next;
  logic [3:0]      cand_code_next;
  logic            confirmed;

  always_comb begin
    slot_tick = (presc == PW'(SCAN_DIV - 1));
    scan_done = slot_tick && (row_idx == 2'd3);
    hits      = ~col_sync;
    row_any   = |hits;
    row_many  = |(hits & (hits - 4'd1));
    casez (hits)
      4'b???1: first_col = 2'd0;
      4'b??10: first_col = 2'd1;
      4'b?100: first_col = 2'd2;
      4'b1000: first_col = 2'd3;
      default: first_col = 2'd0;
    endcase
    // acc_cnt/sum_cnt value 2 stands for "two or more keys"
    if (row_many || (acc_cnt == 2'd2) || ((acc_cnt == 2'd1) && row_any))
      sum_cnt = 2'd2;
    else if ((acc_cnt == 2'd1) || row_any)
      sum_cnt = 2'd1;
    else
      sum_cnt = 2'd0;
    next_code = (acc_cnt == 2'd0) ? {row_idx, first_col} : acc_code;

    res_key = (sum_cnt == 2'd1);
    same    = (res_key == cand_key) && (!res_key || (next_code == cand_code));
    if (!same)
      cnt_next = DW'(1);
    else if (db_cnt == DW'(DEBOUNCE_SCANS))
      cnt_next = db_cnt;
    else
      cnt_next = db_cnt + DW'(1);
    cand_key_next  = res_key;
    cand_code_next = same ? cand_code : next_code;
    confirmed      = (cnt_next == DW'(DEBOUNCE_SCANS));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      col_meta  <= '1;
      col_sync  <= '1;
      presc     <= '0;
      row_idx   <= '0;
      row_out   <= 4'b1110;
      acc_cnt   <= '0;
      acc_code  <= '0;
      cand_key  <= 1'b0;
      cand_code <= '0;
      db_cnt    <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      col_meta  <= col_in;
      col_sync  <= col_meta;
      key_valid <= 1'b0;
      presc     <= slot_tick ? '0 : presc + PW'(1);
      if (slot_tick) begin
        row_idx <= row_idx + 2'd1;
        row_out <= {row_out[2:0], row_out[3]};
        if (scan_done) begin
          acc_cnt   <= '0;
          acc_code  <= '0;
          cand_key  <= cand_key_next;
          cand_code <= cand_code_next;
          db_cnt    <= cnt_next;
          case (state)
            IDLE: begin
              if (cand_key_next && confirmed) begin
                state     <= PRESSED;
                key_code  <= cand_code_next;
                key_held  <= 1'b1;
                key_valid <= 1'b1;
              end
            end
            PRESSED: begin
              if (!cand_key_next && confirmed) begin
                state    <= IDLE;
                key_held <= 1'b0;
              end else if (cand_key_next && confirmed && (cand_code_next != key_code)) begin
                key_code  <= cand_code_next;
                key_valid <= 1'b1;
              end
            end
            default: state <= IDLE;
          endcase
        end else begin
          acc_cnt  <= sum_cnt;
          acc_code <= next_code;
        end
      end
    end
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Scans a 4x4 active-low matrix keypad on one clock domain. It drives one row low at a time in rotation and samples the column inputs. Each full scan is reduced to a single key candidate, which is debounced across consecutive scans. Confirmed key events go to downstream logic as a 4-bit code with a one-cycle valid pulse and a held level. It is the input-side counterpart of the multiplexed seven-segment driver and feeds the values that block displays.

Parameters:
SCAN_DIV, 100000, clk cycles per row slot (must be >= 4)
DEBOUNCE_SCANS, 4, consecutive identical full-scan results required to confirm a press or release (>= 1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
col_in  input  4  keypad columns, active-low (pulled up externally), asynchronous to clk
row_out  output  4  keypad rows, active-low, exactly one bit low at all times
key_code  output  4  last confirmed key, row*4 + col
key_valid  output  1  one-clk pulse on each newly confirmed key
key_held  output  1  high while a confirmed key remains pressed

Behaviour:
- Reset values (async, active-high): row_out=4'b1110, key_code=0, key_valid=0, key_held=0. Prescaler, row index, debounce count, scan accumulator and candidate are cleared to 0/none. FSM enters IDLE. Deasserting rst starts a fresh scan at row 0.
- col_in passes through a 2-flop synchronizer before any use.
- Prescaler counts 0..SCAN_DIV-1 and wraps. The terminal count is the "slot tick".
- On each slot tick, the synchronized columns are sampled for the current row, then the row index advances 0->1->2->3->0.
- Row index to row_out mapping: 0=1110, 1=1101, 2=1011, 3=0111. Each pattern is held for exactly SCAN_DIV clks.
- Scan accumulator across 4 slots:
  - tracks the pressed-key count and the code of the first pressed key, with the lowest row first and then the lowest col (col bit 0 = col 0);
  - the code is row*4+col.
- Scan completes at the row-3 slot tick. Result is:
  - "key C" if exactly one key was pressed;
  - otherwise "none" (zero keys or two or more keys; ghosting and multi-press are rejected).
  - The accumulator then clears.
- Debounce at each scan completion:
  - if the result equals the stored candidate (same code, or both none), the count increments and saturates at DEBOUNCE_SCANS;
  - otherwise the candidate is replaced by the result and the count is set to 1.
- FSM is evaluated on the scan-completion tick using the updated count:
  - IDLE -> PRESSED when the candidate is a key and count == DEBOUNCE_SCANS. key_code <= candidate, key_held <= 1, key_valid pulses.
  - PRESSED -> IDLE when the candidate is none and count == DEBOUNCE_SCANS. key_held <= 0, key_code retained, no pulse.
  - PRESSED, candidate is a key different from key_code, and count == DEBOUNCE_SCANS (rollover): key_code updates, key_valid pulses, key_held stays 1.
  - The same key held while PRESSED produces no further pulses, including while the count is saturated.
- key_valid goes high in the clk cycle immediately after the scan-completion tick, for exactly 1 cycle.
- Latency: a clean press that is stable from a scan boundary gives key_valid DEBOUNCE_SCANS scans (4*SCAN_DIV clks each) later, plus at most 3 clks for the synchronizer and register stage.
- Counter widths are sized from the parameters, e.g. $clog2(SCAN_DIV) bits. There is no overflow beyond saturation.

Test Plan:
- Reset mid-scan with SCAN_DIV=4: assert rst while row_out=1011 -> row_out=1110, key_valid=0, key_held=0, key_code=0 immediately, without a clock edge.
- Idle rotation with SCAN_DIV=4, no key pressed -> row_out cycles 1110,1101,1011,0111, each held 4 clks, then wraps. key_valid never asserts.
- Press key 9 with SCAN_DIV=4, DEBOUNCE_SCANS=2: drive col_in=1101 whenever row_out=1011, for 3 scans.
  - Expect exactly one key_valid pulse, key_code=9, key_held=1.
  - Release for 2 scans: key_held=0, key_code stays 9, no pulse.
- Bounce: key 3 pressed for a single scan, then released -> no key_valid, key_held stays 0.
- Multi-press: keys 0 and 15 pressed together for 4 scans -> result is none, no pulse, key_held=0.
- Rollover: key 5 confirmed, then switch directly to key 10 stable for 2 scans -> second key_valid pulse with key_code=10, and key_held never drops.
